// File: rtl/fp_cmp_share_sched_if.sv
// Requester and subtractor-side signals of the shared FP compare scheduler.
// The slave modport faces the scheduler; the master modport faces requesters and the subtractor.
interface fp_cmp_share_sched_if #(
  parameter int WIDTH = 33,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*(WIDTH+1)-1:0]  req_a;
  logic [NREQ*(WIDTH+1)-1:0]  req_b;
  logic [NREQ-1:0]            req_ready;
  logic [WIDTH:0]             sub_x;
  logic [WIDTH:0]             sub_y;
  logic [WIDTH:0]             sub_r;
  logic [NREQ-1:0]            res_valid;
  logic                       res_le;
  logic                       res_err;
  logic                       busy;
  logic [15:0]                cmp_count;

  modport slave (
    input  req_valid, req_a, req_b, sub_r,
    output req_ready, sub_x, sub_y, res_valid, res_le, res_err, busy, cmp_count
  );

  modport master (
    output req_valid, req_a, req_b, sub_r,
    input  req_ready, sub_x, sub_y, res_valid, res_le, res_err, busy, cmp_count
  );
endinterface

// File: rtl/fp_cmp_share_sched.sv
// Round-robin sharing of one pipelined FloPoCo subtractor between NREQ compare requesters.
// Owner tags ride alongside the subtractor latency; R is decoded into a <= result for the owner.
module fp_cmp_share_sched #(
  parameter int WIDTH   = 33,
  parameter int NREQ    = 4,
  parameter int SUB_LAT = 3
) (
  input logic                 clk,
  input logic                 rst,
  fp_cmp_share_sched_if.slave bus
);
  localparam int W  = WIDTH + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_gid;
  logic            w_acc;

  logic [W-1:0]    r_x_p0;
  logic [W-1:0]    r_y_p0;
  logic [15:0]     r_cnt;

  logic [SUB_LAT:0] r_vld_p;
  logic [PW-1:0]    r_id_p [SUB_LAT+1];

  logic [NREQ-1:0] r_res_valid;
  logic            r_res_le;
  logic            r_res_err;
  logic            w_unused;

  // Returns {le, err} from the exception field and sign of R = A - B.
  function automatic logic [1:0] decode_r(input logic [2:0] exc_sign);
    logic [1:0] d;
    case (exc_sign[2:1])
      2'b00:   d = 2'b10;
      2'b01:   d = {exc_sign[0], 1'b0};
      default: d = 2'b01;
    endcase
    return d;
  endfunction

  always_comb begin
    logic [PW:0] sum;
    w_grant = '0;
    w_gid   = '0;
    w_acc   = 1'b0;
    sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (!w_acc && bus.req_valid[sum[PW-1:0]]) begin
        w_acc = 1'b1;
        w_gid = sum[PW-1:0];
      end
    end
    if (w_acc) w_grant[w_gid] = 1'b1;
  end

  // Stage p0: operand capture, pointer advance and accept count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_x_p0 <= '0;
      r_y_p0 <= '0;
      r_cnt  <= '0;
    end else if (w_acc) begin
      r_x_p0 <= bus.req_a[w_gid*W +: W];
      r_y_p0 <= bus.req_b[w_gid*W +: W];
      r_ptr  <= (w_gid == PW'(NREQ-1)) ? '0 : w_gid + 1'b1;
      if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vld_p <= '0;
    else     r_vld_p <= {r_vld_p[SUB_LAT-1:0], w_acc};
  end

  always_ff @(posedge clk) begin
    r_id_p[0] <= w_gid;
    for (int s = 1; s <= SUB_LAT; s++) r_id_p[s] <= r_id_p[s-1];
  end

  // Stage p(SUB_LAT+1): tag SUB_LAT lines up with R; decode into the owner's strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= '0;
      r_res_le    <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      r_res_valid <= '0;
      if (r_vld_p[SUB_LAT]) begin
        r_res_valid[r_id_p[SUB_LAT]] <= 1'b1;
        {r_res_le, r_res_err}        <= decode_r(bus.sub_r[WIDTH:WIDTH-2]);
      end
    end
  end

  assign w_unused      = &{1'b0, bus.sub_r[WIDTH-3:0]};
  assign bus.req_ready = w_grant;
  assign bus.sub_x     = r_x_p0;
  assign bus.sub_y     = r_y_p0;
  assign bus.res_valid = r_res_valid;
  assign bus.res_le    = r_res_le;
  assign bus.res_err   = r_res_err;
  assign bus.busy      = |r_vld_p;
  assign bus.cmp_count = r_cnt;
endmodule

// File: tb/tb_fp_cmp_share_sched.sv
// Bench for fp_cmp_share_sched: FloPoCo subtractor model, value-level compare scoreboard,
// directed literal pins and randomized request traffic.
module tb_fp_cmp_share_sched;
  localparam int WIDTH   = 33;
  localparam int NREQ    = 4;
  localparam int SUB_LAT = 3;
  localparam int W       = WIDTH + 1;
  localparam int PW      = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  fp_cmp_share_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus();

  fp_cmp_share_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .SUB_LAT(SUB_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] exc, input logic s,
                                      input logic [10:0] e, input logic [19:0] f);
    return {exc, s, e, f};
  endfunction

  // Signed ordering key: zero maps to 0, normals to +-(1.e.f) as an integer.
  function automatic longint key(input logic [W-1:0] v);
    longint mag;
    if (v[W-1:W-2] == 2'b00) return 0;
    mag = longint'({1'b1, v[30:0]});
    return v[31] ? -mag : mag;
  endfunction

  // Expected compare outcome straight from the operand values.
  task automatic ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic le, output logic err);
    if (a[W-1] || b[W-1]) begin
      le = 1'b0; err = 1'b1;
    end else begin
      le = (key(a) <= key(b)); err = 1'b0;
    end
  endtask

  // External subtractor: exact X - Y, exponent/fraction of R filled with noise.
  function automatic logic [W-1:0] sub_fn(input logic [W-1:0] x, input logic [W-1:0] y);
    longint d;
    logic [30:0] junk;
    junk = 31'($urandom);
    if (x[W-1:W-2] == 2'b11 || y[W-1:W-2] == 2'b11 || (x[W-1] && y[W-1]))
      return {2'b11, 1'b0, junk};
    if (x[W-1]) return {2'b10, x[31], junk};
    if (y[W-1]) return {2'b10, ~y[31], junk};
    d = key(x) - key(y);
    if (d == 0) return {2'b00, 1'b0, junk};
    return {2'b01, (d < 0), junk};
  endfunction

  logic [W-1:0] m_rp [SUB_LAT];
  initial for (int i = 0; i < SUB_LAT; i++) m_rp[i] = '0;
  always @(posedge clk) begin
    m_rp[0] <= sub_fn(bus.sub_x, bus.sub_y);
    for (int i = 1; i < SUB_LAT; i++) m_rp[i] <= m_rp[i-1];
  end
  assign bus.sub_r = m_rp[SUB_LAT-1];

  typedef struct {
    int   due;
    int   id;
    logic le;
    logic err;
  } exp_t;

  exp_t q[$];
  int   m_ptr = 0;
  int   m_cnt = 0;
  logic m_le  = 1'b0;
  logic m_err = 1'b0;

  always @(negedge clk) begin
    logic [NREQ-1:0] eg, ev;
    logic [W-1:0]    a, b;
    logic            le, err;
    int              gid, idx;
    if (rst) begin
      chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_count", 64'(bus.cmp_count), 64'(0));
      q.delete();
      m_ptr = 0; m_cnt = 0; m_le = 1'b0; m_err = 1'b0;
    end else begin
      eg = '0; gid = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (gid < 0 && bus.req_valid[idx[PW-1:0]]) gid = idx;
      end
      if (gid >= 0) eg[gid[PW-1:0]] = 1'b1;
      chk("grant", 64'(bus.req_ready), 64'(eg));

      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      ev = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ev[q[0].id[PW-1:0]] = 1'b1;
        m_le  = q[0].le;
        m_err = q[0].err;
        void'(q.pop_front());
      end
      chk("res_valid", 64'(bus.res_valid), 64'(ev));
      chk("res_le", 64'(bus.res_le), 64'(m_le));
      chk("res_err", 64'(bus.res_err), 64'(m_err));
      chk("busy", 64'(bus.busy), 64'(q.size() != 0));
      chk("cmp_count", 64'(bus.cmp_count), 64'(m_cnt));

      if (gid >= 0) begin
        a = bus.req_a[gid*W +: W];
        b = bus.req_b[gid*W +: W];
        ref_cmp(a, b, le, err);
        q.push_back('{cyc + SUB_LAT + 2, gid, le, err});
        m_ptr = (gid + 1) % NREQ;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic single(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic le, input logic err, input string nm);
    bus.req_valid = '0;
    bus.req_valid[id[PW-1:0]] = 1'b1;
    set_op(id, a, b);
    #1;
    chk({nm, "_ready"}, 64'(bus.req_ready), 64'(1) << id);
    step();
    bus.req_valid = '0;
    repeat (3) step();
    chk({nm, "_early"}, 64'(bus.res_valid), 64'(0));
    step();
    chk({nm, "_valid"}, 64'(bus.res_valid), 64'(1) << id);
    chk({nm, "_le"}, 64'(bus.res_le), 64'(le));
    chk({nm, "_err"}, 64'(bus.res_err), 64'(err));
    repeat (2) step();
  endtask

  function automatic logic [W-1:0] gen_fp();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return mk(2'b00, 1'($urandom), 11'($urandom), 20'($urandom));
    if (r == 1) return mk(2'b10, 1'($urandom), 11'h7FF, 20'h0);
    if (r == 2) return mk(2'b11, 1'b0, 11'h7FF, 20'($urandom));
    return mk(2'b01, 1'($urandom), 11'h3FD + 11'($urandom_range(0, 3)), 20'($urandom_range(0, 3)));
  endfunction

  logic [W-1:0] one_p0, two_p0, nan_v;

  initial begin
    one_p0 = mk(2'b01, 1'b0, 11'h3FF, 20'h0);
    two_p0 = mk(2'b01, 1'b0, 11'h400, 20'h0);
    nan_v  = mk(2'b11, 1'b0, 11'h7FF, 20'h1);
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    rst = 1'b1;
    repeat (2) step();
    chk("init_sub_x", 64'(bus.sub_x), 64'(0));
    chk("init_sub_y", 64'(bus.sub_y), 64'(0));
    chk("init_res_le", 64'(bus.res_le), 64'(0));
    chk("init_res_err", 64'(bus.res_err), 64'(0));
    rst = 1'b0;
    step();

    single(2, one_p0, two_p0, 1'b1, 1'b0, "one_le_two");
    single(1, two_p0, two_p0, 1'b1, 1'b0, "equal");
    single(3, two_p0, one_p0, 1'b0, 1'b0, "greater");
    single(0, nan_v, one_p0, 1'b0, 1'b1, "nan");

    // Round-robin fairness from reset
    do_reset();
    bus.req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_op(i, gen_fp(), gen_fp());
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_grant", 64'(bus.req_ready), 64'(1) << (k % 4));
      step();
    end
    bus.req_valid = '0;
    chk("rr_count", 64'(bus.cmp_count), 64'd8);
    repeat (6) step();

    // Pointer skip and wrap starting from ptr=3
    do_reset();
    single(2, one_p0, one_p0, 1'b1, 1'b0, "ptr_setup");
    bus.req_valid = 4'b0101;
    #1; chk("skip_g0", 64'(bus.req_ready), 64'b0001); step();
    #1; chk("skip_g1", 64'(bus.req_ready), 64'b0100); step();
    #1; chk("skip_g2", 64'(bus.req_ready), 64'b0001); step();
    bus.req_valid = '0;
    repeat (6) step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.req_valid = ($urandom_range(0, 4) == 0) ? '0 : NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        logic [W-1:0] a;
        a = gen_fp();
        set_op(i, a, ($urandom_range(0, 3) == 0) ? a : gen_fp());
      end
      step();
    end
    bus.req_valid = '0;
    repeat (6) step();

    // Reset while three compares are in flight
    do_reset();
    bus.req_valid = 4'b0111;
    for (int i = 0; i < NREQ; i++) set_op(i, gen_fp(), gen_fp());
    repeat (3) step();
    bus.req_valid = '0;
    repeat (2) step();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_count", 64'(bus.cmp_count), 64'(0));
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("midrst_no_result", 64'(bus.res_valid), 64'(0));
    end
    bus.req_valid = '1;
    #1;
    chk("midrst_first_grant", 64'(bus.req_ready), 64'b0001);
    step();
    bus.req_valid = '0;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/fp_cmp_share_sched.md
Name: fp_cmp_share_sched

Overview:
- Round-robin scheduler that shares one pipelined FloPoCo FP subtractor (11-bit exponent, 20-bit fraction, 34-bit word with a 2-bit exception field) between NREQ compare requesters in the Ray-AABB datapath.
- Typical requesters are the slab tmin/tmax compare stages.
- Accepts at most one request per cycle and drives operands to the external subtractor.
- Tracks each in-flight request's owner through a tag pipeline matched to the subtractor latency, decodes R into a less-or-equal result, and returns it to the originating requester.

Parameters:
- WIDTH, 33: MSB index of an FP word (word is WIDTH+1 = 34 bits: [33:32] exception, [31] sign, [30:20] exponent, [19:0] fraction).
- NREQ, 4: number of requesters, 2..8.
- SUB_LAT, 3: subtractor pipeline latency in cycles, 1..16.

Ports:
- clk input 1: clock.
- rst input 1: reset, asynchronous, active-high.
- req_valid input NREQ: request pending per requester.
- req_a input NREQ*(WIDTH+1): flattened operand A; requester i uses slice i.
- req_b input NREQ*(WIDTH+1): flattened operand B.
- req_ready output NREQ: one-hot grant, combinational.
- sub_x output WIDTH+1: registered operand to subtractor X.
- sub_y output WIDTH+1: registered operand to subtractor Y.
- sub_r input WIDTH+1: subtractor result R = X - Y.
- res_valid output NREQ: one-cycle result strobe per requester.
- res_le output 1: 1 when A <= B.
- res_err output 1: R exception was inf or NaN.
- busy output 1: any compare in flight.
- cmp_count output 16: accepted compare count, saturating.

Behaviour:
- Reset values:
  - sub_x, sub_y, res_valid, res_le, res_err, busy: 0.
  - cmp_count: 0.
  - RR pointer: 0.
  - Tag pipeline: all invalid.
- Arbitration:
  - Search starts at index ptr and wraps modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - req_ready is 0 for every index when no request is valid.
- Accept is req_valid[i] & req_ready[i] at a clk edge. On accept:
  - sub_x <= slice i of req_a; sub_y <= slice i of req_b.
  - ptr <= (i+1) mod NREQ.
  - A tag {valid=1, id=i} enters tag stage 0.
- With no accept, sub_x and sub_y hold, and an invalid tag enters the pipeline.
- Tag pipeline is SUB_LAT+1 stages deep. Tag stage SUB_LAT aligns with sub_r for that request, so R for an accept at edge t is valid during cycle t+SUB_LAT.
- Decode is registered on the next edge. res_valid[id] pulses for one cycle, SUB_LAT+1 cycles after the accept edge, with res_le and res_err set as follows:
  - exc 00 (zero): le=1, err=0.
  - exc 01, sign 1: le=1, err=0.
  - exc 01, sign 0: le=0, err=0.
  - exc 10 or 11: le=0, err=1.
- When no result is valid, res_valid is all 0. res_le and res_err hold their last values.
- Throughput is one compare per cycle. Back-to-back accepts produce back-to-back results, in accept order.
- Results carry no backpressure: requesters must accept the res_valid pulse.
- A requester may keep req_valid high across cycles. Each accept is a separate compare, with operands sampled at its accept edge.
- busy = OR of tag valid bits in stages 0..SUB_LAT.
- cmp_count increments on each accept and saturates at 0xFFFF.
- Reset mid-operation clears all tags: in-flight results are discarded and no res_valid follows. ptr returns to 0.

Test Plan:
- Single request, NREQ=4, SUB_LAT=3: req 2 with A=1.0 {01,0,0x3FF,0}, B=2.0 {01,0,0x400,0}. Expect req_ready=0100 in the same cycle, and res_valid=0100 with res_le=1, res_err=0 exactly 4 cycles after accept.
- Equality and greater: A=B=2.0 gives R exc 00 and res_le=1. A=2.0, B=1.0 gives res_le=0.
- Round-robin fairness: req_valid=1111 held for 8 cycles from reset. Expect grant order 0,1,2,3,0,1,2,3; results in the same order, one per cycle; cmp_count=8.
- Pointer skip and wrap: ptr=3, req_valid=0101. Expect grant 0, then 2, then 0.
- Exception: model returns R exc 11 (NaN). Expect res_le=0 and res_err=1 on the owner's strobe.
- Reset mid-flight: assert rst 2 cycles after three accepts. Expect no res_valid afterwards, busy=0, cmp_count=0, and next grant starting from index 0.
